conf_window: RTL and testbench

Parametrised configuration-register window for the QSIC Qbus interface. It exposes three Qbus I/O-page registers: address (CAR), data (CDR) and control/status (CSR). Bus accesses become handshaked read/write transactions on an internal configuration bus shared by `NSRC` configuration sources. It adds the following:
- prefetch of read data;
- optional address auto-increment;
- per-source acknowledge;
- a timeout;
- sticky error status.

---
 rtl/conf_window.sv | 200 ++++++++++++++++++++
 tb/tb_conf_window.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_window.sv
// Qbus CAR/CDR/CSR register window onto a shared configuration bus: read
// prefetch, optional CAR auto-increment, per-source ack, timeout, sticky errors.
module conf_window #(
    parameter logic [12:0] ADDR_BASE  = 13'o17760,
    parameter int          NSRC       = 5,
    parameter int          STRIDE     = 1,
    parameter int          TMO_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [12:0]        reg_addr,
    input  logic               reg_bs7,
    output logic               reg_addr_match,
    output logic [15:0]        reg_rdata,
    input  logic [15:0]        reg_wdata,
    input  logic               reg_read,
    input  logic               reg_write,
    output logic [15:0]        conf_addr,
    output logic [15:0]        conf_wdata,
    output logic               conf_rd,
    output logic               conf_wr,
    input  logic [NSRC-1:0]    src_match,
    input  logic [16*NSRC-1:0] src_rdata,
    input  logic [NSRC-1:0]    src_ack
);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] car_q, car_d;
    logic [15:0] cdr_q, cdr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        ainc_q, ainc_d;
    logic        ovr_q, ovr_d;
    logic        multi_q, multi_d;
    logic        nomatch_q, nomatch_d;
    logic        tmo_q, tmo_d;
    logic        rd_q, rd_d;
    logic        inc_q, inc_d;

    logic        hit_car, hit_cdr, hit_csr;
    logic        wr_car, wr_cdr, wr_csr, rd_cdr;
    logic        busy;
    logic [15:0] csr;
    logic [3:0]  first_idx;
    logic        multi_hit;
    logic [15:0]  ack_ext;
    logic [255:0] rdata_ext;
    logic        ack_sel;
    logic [15:0] rdata_sel;

    assign hit_car = reg_bs7 && (reg_addr == ADDR_BASE);
    assign hit_cdr = reg_bs7 && (reg_addr == ADDR_BASE + 13'd2);
    assign hit_csr = reg_bs7 && (reg_addr == ADDR_BASE + 13'd4);
    assign reg_addr_match = hit_car || hit_cdr || hit_csr;

    assign wr_car = reg_write && hit_car;
    assign wr_cdr = reg_write && hit_cdr;
    assign wr_csr = reg_write && hit_csr;
    assign rd_cdr = reg_read && hit_cdr;

    assign busy = (state_q != S_IDLE);
    assign csr  = {tmo_q, nomatch_q, multi_q, ovr_q, 4'b0, busy, 6'b0, ainc_q};

    always_comb begin
        reg_rdata = 16'h0;
        if (hit_car)      reg_rdata = car_q;
        else if (hit_cdr) reg_rdata = cdr_q;
        else if (hit_csr) reg_rdata = csr;
    end

    assign conf_addr  = car_q;
    assign conf_wdata = wdata_q;
    assign conf_rd    = (state_q == S_WAIT) && rd_q;
    assign conf_wr    = (state_q == S_WAIT) && !rd_q;

    // Lowest-numbered matching source owns the transaction.
    always_comb begin
        first_idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_match[i]) first_idx = 4'(i);
        end
    end
    assign multi_hit = ($countones(src_match) > 1);

    assign ack_ext   = 16'(src_ack);
    assign rdata_ext = 256'(src_rdata);
    assign ack_sel   = ack_ext[sel_q];
    assign rdata_sel = rdata_ext[{sel_q, 4'b0} +: 16];

    always_comb begin
        state_d   = state_q;
        car_d     = car_q;
        cdr_d     = cdr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ainc_d    = ainc_q;
        ovr_d     = ovr_q;
        multi_d   = multi_q;
        nomatch_d = nomatch_q;
        tmo_d     = tmo_q;
        rd_d      = rd_q;
        inc_d     = inc_q;

        // W1C first so an error raised in the same cycle still sticks.
        if (wr_csr) begin
            ainc_d = reg_wdata[0];
            if (reg_wdata[12]) ovr_d     = 1'b0;
            if (reg_wdata[13]) multi_d   = 1'b0;
            if (reg_wdata[14]) nomatch_d = 1'b0;
            if (reg_wdata[15]) tmo_d     = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_car) begin
                    car_d   = reg_wdata;
                    rd_d    = 1'b1;
                    inc_d   = 1'b0;
                    state_d = S_SEL;
                end else if (wr_cdr) begin
                    wdata_d = reg_wdata;
                    rd_d    = 1'b0;
                    inc_d   = ainc_q;
                    state_d = S_SEL;
                end else if (rd_cdr && ainc_q) begin
                    car_d   = car_q + 16'(STRIDE);
                    rd_d    = 1'b1;
                    inc_d   = 1'b0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (src_match == '0) begin
                    nomatch_d = 1'b1;
                    if (rd_q) cdr_d = 16'hFFFF;
                    state_d = S_IDLE;
                end else begin
                    sel_d = first_idx;
                    if (multi_hit) multi_d = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_sel) begin
                    if (rd_q)  cdr_d = rdata_sel;
                    if (inc_q) car_d = car_q + 16'(STRIDE);
                    state_d = S_IDLE;
                end else if (cnt_q == 16'(TMO_CYCLES - 1)) begin
                    tmo_d = 1'b1;
                    if (rd_q)  cdr_d = 16'hFFFF;
                    if (inc_q) car_d = car_q + 16'(STRIDE);
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busy && (wr_car || wr_cdr)) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            car_q     <= 16'h0;
            cdr_q     <= 16'h0;
            wdata_q   <= 16'h0;
            cnt_q     <= 16'h0;
            sel_q     <= 4'd0;
            ainc_q    <= 1'b0;
            ovr_q     <= 1'b0;
            multi_q   <= 1'b0;
            nomatch_q <= 1'b0;
            tmo_q     <= 1'b0;
            rd_q      <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            car_q     <= car_d;
            cdr_q     <= cdr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ainc_q    <= ainc_d;
            ovr_q     <= ovr_d;
            multi_q   <= multi_d;
            nomatch_q <= nomatch_d;
            tmo_q     <= tmo_d;
            rd_q      <= rd_d;
            inc_q     <= inc_d;
        end
    end

endmodule

// File: tb/tb_conf_window.sv
// Bench for conf_window: table of register accesses with expected results,
// a strobe scoreboard, and hand-written overrun and reset-abort sequences.
module tb_conf_window;

    localparam int NSRC = 5;
    localparam int TMO  = 8;
    localparam int CAR = 0, CDR = 1, CSR = 2;

    logic              clk;
    logic              reset;
    logic [12:0]       reg_addr;
    logic              reg_bs7;
    logic              reg_addr_match;
    logic [15:0]       reg_rdata;
    logic [15:0]       reg_wdata;
    logic              reg_read;
    logic              reg_write;
    logic [15:0]       conf_addr;
    logic [15:0]       conf_wdata;
    logic              conf_rd;
    logic              conf_wr;
    logic [NSRC-1:0]   src_match;
    logic [16*NSRC-1:0] src_rdata;
    logic [NSRC-1:0]   src_ack;

    conf_window #(.ADDR_BASE(13'o17760), .NSRC(NSRC), .STRIDE(1), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_bs7(reg_bs7),
        .reg_addr_match(reg_addr_match), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata),
        .reg_read(reg_read), .reg_write(reg_write), .conf_addr(conf_addr),
        .conf_wdata(conf_wdata), .conf_rd(conf_rd), .conf_wr(conf_wr),
        .src_match(src_match), .src_rdata(src_rdata), .src_ack(src_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Source model: fixed read data, bench-controlled match and ack timing.
    logic [4:0] ackm_v, ackx_v;
    int         dly_v;
    int         run_len = 0;
    int         last_len = 0;
    assign src_rdata = {16'hA004, 16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
    assign src_ack = (conf_rd || conf_wr) ?
                     (((run_len == dly_v + 1) ? ackm_v : 5'b0) | ((run_len >= 1) ? ackx_v : 5'b0)) : 5'b0;

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        logic [15:0] wd;
    } sb_t;
    sb_t sb[$];
    sb_t e;

    always @(negedge clk) begin
        if (conf_rd || conf_wr) begin
            if (run_len == 0) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe: got rd=%0b wr=%0b addr %h, expected no transaction", conf_rd, conf_wr, conf_addr);
                end else begin
                    e = sb.pop_front();
                    if (conf_rd !== e.rd || conf_wr !== !e.rd || conf_addr !== e.addr ||
                        (!e.rd && conf_wdata !== e.wd)) begin
                        n_err++;
                        $display("FAIL strobe: got rd=%0b addr %h wd %h, expected rd=%0b addr %h wd %h",
                                 conf_rd, conf_addr, conf_wdata, e.rd, e.addr, e.wd);
                    end
                end
            end
            run_len = run_len + 1;
        end else begin
            if (run_len != 0) last_len = run_len;
            run_len = 0;
        end
    end

    function automatic logic [12:0] addr_of(input int rg);
        return 13'o17760 + 13'(2 * rg);
    endfunction

    task automatic bus_write(input int rg, input logic [15:0] d);
        @(negedge clk);
        reg_addr = addr_of(rg); reg_bs7 = 1'b1; reg_wdata = d; reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic bus_read(input int rg, output logic [15:0] d);
        @(negedge clk);
        reg_addr = addr_of(rg); reg_bs7 = 1'b1; reg_read = 1'b1;
        #1 d = reg_rdata;
        @(negedge clk);
        reg_read = 1'b0;
    endtask

    task automatic peek(input int rg, output logic [15:0] d);
        reg_addr = addr_of(rg); reg_bs7 = 1'b1;
        #1 d = reg_rdata;
    endtask

    task automatic wait_idle(input string name, output int n);
        logic [15:0] v;
        n = 0;
        peek(CSR, v);
        while (v[7] && n < 200) begin
            n++;
            @(negedge clk);
            peek(CSR, v);
        end
        if (v[7]) begin
            n_chk++; n_err++;
            $display("FAIL %s.idle: got BUSY still 1 after %0d cycles, expected idle", name, n);
        end
    endtask

    typedef struct {
        string       nm;
        int          rg;
        bit          wr;
        logic [15:0] wd;
        logic [4:0]  m, am, ax;
        int          dly;
        int          ek;
        logic [15:0] ea, ewd;
        int          crg;
        logic [15:0] cexp;
        int          eb, es;
        logic [15:0] erv;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string nm, input int rg, input bit wr, input logic [15:0] wd,
                       input logic [4:0] m, input logic [4:0] am, input int dly, input logic [4:0] ax,
                       input int ek, input logic [15:0] ea, input logic [15:0] ewd,
                       input int crg, input logic [15:0] cexp, input int eb, input int es,
                       input logic [15:0] erv);
        vec_t v;
        v.nm = nm; v.rg = rg; v.wr = wr; v.wd = wd; v.m = m; v.am = am; v.dly = dly; v.ax = ax;
        v.ek = ek; v.ea = ea; v.ewd = ewd; v.crg = crg; v.cexp = cexp; v.eb = eb; v.es = es; v.erv = erv;
        tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, rv;
        int nb;
        sb_t s;

        reset = 1'b1; reg_addr = '0; reg_bs7 = 1'b0; reg_wdata = '0;
        reg_read = 1'b0; reg_write = 1'b0; src_match = '0;
        ackm_v = '0; ackx_v = '0; dly_v = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        peek(CAR, v); check("rst.car", v, 16'h0);
        check("rst.match", 16'(reg_addr_match), 16'h1);
        peek(CDR, v); check("rst.cdr", v, 16'h0);
        peek(CSR, v); check("rst.csr", v, 16'h0);
        check("rst.strobes", {14'b0, conf_rd, conf_wr}, 16'h0);
        check("rst.wdata", conf_wdata, 16'h0);
        reg_bs7 = 1'b0; #1;
        check("nobs7.match", 16'(reg_addr_match), 16'h0);
        check("nobs7.rdata", reg_rdata, 16'h0);
        reg_bs7 = 1'b1; reg_addr = 13'o17766; #1;
        check("miss.match", 16'(reg_addr_match), 16'h0);

        //   name        reg  wr  wdata    match    ackm     dly ackx     ek  eaddr    ewdata   chk  exp      busy slen rdval
        add("car_fetch", CAR, 1, 16'h0010, 5'b00100, 5'b00100, 3, 5'b00000, 1, 16'h0010, 16'h0000, CDR, 16'hBEEF, 5, 4, 16'h0);
        add("err_zero",  CSR, 1, 16'h0000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0000, 0, 0, 16'h0);
        add("car_ffff",  CAR, 1, 16'hFFFF, 5'b00001, 5'b00001, 0, 5'b00000, 1, 16'hFFFF, 16'h0000, CDR, 16'hA000, 2, 1, 16'h0);
        add("ainc_on",   CSR, 1, 16'h0001, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0001, 0, 0, 16'h0);
        add("ainc_rd1",  CDR, 0, 16'h0000, 5'b00010, 5'b00010, 0, 5'b00000, 1, 16'h0000, 16'h0000, CAR, 16'h0000, 2, 1, 16'hA000);
        add("ainc_rd2",  CDR, 0, 16'h0000, 5'b00001, 5'b00001, 0, 5'b00000, 1, 16'h0001, 16'h0000, CAR, 16'h0001, 2, 1, 16'hA001);
        add("ainc_off",  CSR, 1, 16'h0000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0000, 0, 0, 16'h0);
        add("nomatch",   CDR, 1, 16'h1234, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h4000, 1, 0, 16'h0);
        add("nm_cdr",    CAR, 0, 16'h0000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CDR, 16'hA000, 0, 0, 16'h0001);
        add("nm_clear",  CSR, 1, 16'hC000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0000, 0, 0, 16'h0);
        add("multi_wr",  CDR, 1, 16'h00AA, 5'b01010, 5'b00010, 2, 5'b01000, 2, 16'h0001, 16'h00AA, CSR, 16'h2000, 4, 3, 16'h0);
        add("multi_clr", CSR, 1, 16'h2000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0000, 0, 0, 16'h0);
        add("tmo_rd",    CAR, 1, 16'h0040, 5'b00001, 5'b00000, 0, 5'b00000, 1, 16'h0040, 16'h0000, CDR, 16'hFFFF, 9, 8, 16'h0);
        add("tmo_csr",   CAR, 0, 16'h0000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h8000, 0, 0, 16'h0040);
        add("tmo_clr",   CSR, 1, 16'h8001, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0001, 0, 0, 16'h0);
        add("tmo_wrinc", CDR, 1, 16'h5555, 5'b00001, 5'b00000, 0, 5'b00000, 2, 16'h0040, 16'h5555, CAR, 16'h0041, 9, 8, 16'h0);
        add("tmo_clr2",  CSR, 1, 16'h8001, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0001, 0, 0, 16'h0);
        add("ack_wrinc", CDR, 1, 16'h7777, 5'b00100, 5'b00100, 1, 5'b00000, 2, 16'h0041, 16'h7777, CAR, 16'h0042, 3, 2, 16'h0);
        add("ainc_off2", CSR, 1, 16'h0000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 16'h0000, 16'h0000, CSR, 16'h0000, 0, 0, 16'h0);
        add("rd_noinc",  CDR, 0, 16'h0000, 5'b00001, 5'b00001, 0, 5'b00000, 0, 16'h0000, 16'h0000, CAR, 16'h0042, 0, 0, 16'hFFFF);

        foreach (tbl[i]) begin
            last_len = 0;
            src_match = tbl[i].m; ackm_v = tbl[i].am; ackx_v = tbl[i].ax; dly_v = tbl[i].dly;
            if (tbl[i].ek != 0) begin
                s.rd = (tbl[i].ek == 1); s.addr = tbl[i].ea; s.wd = tbl[i].ewd;
                sb.push_back(s);
            end
            if (tbl[i].wr) begin
                bus_write(tbl[i].rg, tbl[i].wd);
            end else begin
                bus_read(tbl[i].rg, rv);
                check($sformatf("%s.rdata", tbl[i].nm), rv, tbl[i].erv);
            end
            wait_idle(tbl[i].nm, nb);
            check($sformatf("%s.busy", tbl[i].nm), 16'(nb), 16'(tbl[i].eb));
            check($sformatf("%s.slen", tbl[i].nm), 16'(last_len), 16'(tbl[i].es));
            peek(tbl[i].crg, v);
            check($sformatf("%s.reg", tbl[i].nm), v, tbl[i].cexp);
        end

        // CAR write while a read is waiting for an ack that never comes.
        src_match = 5'b00001; ackm_v = 5'b0; ackx_v = 5'b0;
        s.rd = 1'b1; s.addr = 16'h0100; s.wd = 16'h0; sb.push_back(s);
        bus_write(CAR, 16'h0100);
        @(negedge clk);
        bus_write(CAR, 16'h0200);
        wait_idle("ovr", nb);
        peek(CAR, v); check("ovr.car", v, 16'h0100);
        peek(CSR, v); check("ovr.csr", v, 16'h9000);
        bus_write(CSR, 16'h9000);
        wait_idle("ovr_clr", nb);
        peek(CSR, v); check("ovr_clr.csr", v, 16'h0000);

        // Reset in the second WAIT cycle aborts the transaction cleanly.
        s.rd = 1'b1; s.addr = 16'h0300; sb.push_back(s);
        bus_write(CAR, 16'h0300);
        @(negedge clk);
        @(negedge clk);
        check("rstmid.pre", 16'(conf_rd), 16'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid.strobes", {14'b0, conf_rd, conf_wr}, 16'h0);
        peek(CAR, v); check("rstmid.car", v, 16'h0);
        peek(CDR, v); check("rstmid.cdr", v, 16'h0);
        peek(CSR, v); check("rstmid.csr", v, 16'h0);
        check("rstmid.wdata", conf_wdata, 16'h0);

        repeat (2) @(negedge clk);
        check("sb.empty", 16'(sb.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
